// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
package fwd_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned REG_W_DEF = 5;
  localparam int unsigned SEL_NONE  = 0;

  typedef struct packed {
    logic                 v;
    logic [REG_W_DEF-1:0] rd;
    logic                 ld;
  } trk_entry_t;

  // Select code for producer stage k: youngest stage gets the largest code.
  function automatic int unsigned sel_of_stage(input int unsigned k, input int unsigned depth);
    return depth - k;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// (DEPTH+1):1 operand select: code 0 keeps the own operand, else a producer stage.
module fwd_mux
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SELW  = 2
) (
  input  logic [SELW-1:0]       sel,
  input  logic [XLEN-1:0]       opnd,
  input  logic [DEPTH*XLEN-1:0] stage_data,
  output logic [XLEN-1:0]       y
);

  always_comb begin
    y = opnd;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (sel == SELW'(sel_of_stage(k, DEPTH))) y = stage_data[k*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand forwarding unit: tracks post-EX writers, picks the youngest eligible
// producer per source operand, flags load-use hazards and counts forwards.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned NSRC  = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        adv_i,
  input  logic                        flush_i,
  input  logic                        ex_valid_i,
  input  logic [REG_W-1:0]            ex_rd_i,
  input  logic                        ex_regwrite_i,
  input  logic                        ex_memread_i,
  input  logic [NSRC*REG_W-1:0]       ex_rs_i,
  input  logic [NSRC*XLEN-1:0]        ex_opnd_i,
  input  logic [DEPTH*XLEN-1:0]       stage_data_i,
  input  logic                        id_valid_i,
  input  logic [NSRC*REG_W-1:0]       id_rs_i,
  output logic [NSRC*XLEN-1:0]        fwd_data_o,
  output logic [NSRC*$clog2(DEPTH+1)-1:0] fwd_sel_o,
  output logic                        load_use_stall_o,
  output logic [31:0]                 fwd_cnt_o
);

  localparam int unsigned SELW  = $clog2(DEPTH + 1);
  localparam int unsigned HIT_W = $clog2(NSRC + 1);
  localparam int unsigned CNT_W = 32;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [DEPTH-1:0] trk_v;
  logic [DEPTH-1:0] trk_ld;
  logic [REG_W-1:0] trk_rd [DEPTH];

  logic [NSRC*SELW-1:0] sel_c;
  logic [HIT_W-1:0]     hits_c;
  logic [REG_W-1:0]     rs_c;
  logic                 found_c;
  logic                 stall_hit_c;
  logic [CNT_W-1:0]     cnt_q;
  logic [SUM_W-1:0]     cnt_sum_c;

  // Scoreboard shift; a flush without advance only kills the youngest entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trk_v  <= '0;
      trk_ld <= '0;
      for (int k = 0; k < DEPTH; k++) trk_rd[k] <= '0;
    end else if (adv_i) begin
      for (int k = 1; k < DEPTH; k++) begin
        trk_v[k]  <= trk_v[k-1];
        trk_rd[k] <= trk_rd[k-1];
        trk_ld[k] <= trk_ld[k-1];
      end
      trk_v[0]  <= ex_valid_i & ex_regwrite_i & (ex_rd_i != '0) & ~flush_i;
      trk_rd[0] <= ex_rd_i;
      trk_ld[0] <= ex_memread_i;
    end else if (flush_i) begin
      trk_v[0] <= 1'b0;
    end
  end

  // Youngest-first match; a load still in stage 0 has no data yet.
  always_comb begin
    sel_c   = '0;
    hits_c  = '0;
    rs_c    = '0;
    found_c = 1'b0;
    for (int unsigned n = 0; n < NSRC; n++) begin
      rs_c    = ex_rs_i[n*REG_W +: REG_W];
      found_c = 1'b0;
      sel_c[n*SELW +: SELW] = SELW'(SEL_NONE);
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (!found_c && trk_v[k] && (trk_rd[k] == rs_c) && (rs_c != '0) &&
            ((k != 0) || !trk_ld[k])) begin
          sel_c[n*SELW +: SELW] = SELW'(sel_of_stage(k, DEPTH));
          found_c = 1'b1;
        end
      end
      if (found_c) hits_c = hits_c + HIT_W'(1);
    end
  end

  for (genvar n = 0; n < NSRC; n++) begin : g_mux
    fwd_mux #(
      .XLEN (XLEN),
      .DEPTH(DEPTH),
      .SELW (SELW)
    ) u_mux (
      .sel       (sel_c[n*SELW +: SELW]),
      .opnd      (ex_opnd_i[n*XLEN +: XLEN]),
      .stage_data(stage_data_i),
      .y         (fwd_data_o[n*XLEN +: XLEN])
    );
  end

  assign fwd_sel_o = sel_c;

  always_comb begin
    stall_hit_c = 1'b0;
    for (int unsigned n = 0; n < NSRC; n++) begin
      if (id_rs_i[n*REG_W +: REG_W] == ex_rd_i) stall_hit_c = 1'b1;
    end
  end

  assign load_use_stall_o = ~rst_i & id_valid_i & ex_valid_i & ex_memread_i &
                            ex_regwrite_i & (ex_rd_i != '0) & stall_hit_c;

  // Saturating event counter; the extra sum bit detects overflow.
  assign cnt_sum_c = {1'b0, cnt_q} + SUM_W'(hits_c);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (adv_i && ex_valid_i && !flush_i) begin
      cnt_q <= cnt_sum_c[CNT_W] ? '1 : cnt_sum_c[CNT_W-1:0];
    end
  end

  assign fwd_cnt_o = cnt_q;

endmodule
